// File: rtl/bfp_pkg.sv
// Shared block-floating-point constants and stream FSM state encoding.
// Used by the exponent restore, reciprocal and max-exponent finder blocks.
package bfp_pkg;

    localparam int EXP_W   = 4;
    localparam int BIAS    = 1 << (EXP_W - 1);
    localparam int FRAME   = 64;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/exp_restore_lane.sv
// Purpose: one lane of exponent denormalisation, e + max_exp - BIAS with zero/underflow/saturate.
// Latency: combinational.
// Backpressure: none; the parent's output register provides the handshake.
module exp_restore_lane
    import bfp_pkg::*;
(
    input  logic [EXP_W-1:0] e,
    input  logic [EXP_W-1:0] max_exp,
    output logic [EXP_W-1:0] r,
    output logic             sat
);

    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(BIAS);
    localparam logic signed [EXP_W+1:0] MAX_S  = (EXP_W + 2)'(EXP_MAX);

    logic signed [EXP_W+1:0] t;

    always_comb begin
        t   = $signed({2'b00, e}) + $signed({2'b00, max_exp}) - BIAS_S;
        r   = '0;
        sat = 1'b0;
        // A zero input is a zero/denormal and must stay zero whatever max_exp is.
        if (e == '0) begin
            r = '0;
        end else if (t[EXP_W+1] || (t == '0)) begin
            r = '0;
        end else if (t > MAX_S) begin
            r   = EXP_W'(EXP_MAX);
            sat = 1'b1;
        end else begin
            r = t[EXP_W-1:0];
        end
    end

endmodule

// File: rtl/block_exp_restore.sv
// Purpose: streaming exponent denormaliser; one block exponent per frame, then FRAME/LANES beats.
// Latency: 1 cycle from input handshake to out_valid; full rate with continuous out_ready.
// Backpressure: in_ready = !out_valid || out_ready in STREAM; EXP_RESTORE_OVF_FLAG_EN adds ovf_flag.
module block_exp_restore
    import bfp_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   blk_exp_valid,
    output logic                   blk_exp_ready,
    input  logic [EXP_W-1:0]       blk_exp,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*EXP_W-1:0] in_exp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*EXP_W-1:0] out_exp,
    output logic                   out_last
`ifdef EXP_RESTORE_OVF_FLAG_EN
    ,
    output logic                   ovf_flag
`endif
);

    localparam int BEATS = FRAME / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    state_t                   state_q, state_d;
    logic [EXP_W-1:0]         max_exp_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [LANES*EXP_W-1:0]   restored;
    logic [LANES-1:0]         lane_sat;
    logic                     blk_hs;
    logic                     in_hs;
    logic                     last_beat;

    for (genvar i = 0; i < LANES; i++) begin : gen_lane
        exp_restore_lane u_lane (
            .e       (in_exp[EXP_W*i +: EXP_W]),
            .max_exp (max_exp_q),
            .r       (restored[EXP_W*i +: EXP_W]),
            .sat     (lane_sat[i])
        );
    end

    assign last_beat = (cnt_q == LAST_CNT);
    assign blk_hs    = blk_exp_valid && blk_exp_ready;
    assign in_hs     = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        blk_exp_ready = 1'b0;
        in_ready      = 1'b0;
        case (state_q)
            IDLE: begin
                blk_exp_ready = 1'b1;
                if (blk_exp_valid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            max_exp_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (blk_hs) begin
                max_exp_q <= blk_exp;
                cnt_q     <= '0;
            end else if (in_hs) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Output register keeps its data after a pop; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_last  <= 1'b0;
        end else if (in_hs) begin
            out_valid <= 1'b1;
            out_exp   <= restored;
            out_last  <= last_beat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef EXP_RESTORE_OVF_FLAG_EN
    // The flag travels with its beat so a stalled out_last keeps its own frame's value.
    logic ovf_acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_acc_q <= 1'b0;
            ovf_flag  <= 1'b0;
        end else begin
            if (blk_hs) begin
                ovf_acc_q <= 1'b0;
            end else if (in_hs) begin
                ovf_acc_q <= ovf_acc_q | (|lane_sat);
            end
            if (in_hs) begin
                ovf_flag <= ovf_acc_q | (|lane_sat);
            end
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^lane_sat;
`endif

endmodule
